// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - two-lane striping serializer, 32-bit words MSB-first, comma-filled idle frames
module phy_tx_serializer #(
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         IDLE_FRAMES = 1
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        phy_tx_out_0,
  output logic        phy_tx_out_1,
  output logic        lane_active_0,
  output logic        lane_active_1
);

  localparam logic [31:0] IDLE_WORD = {4{IDLE_BYTE}};
  // idle_cnt counts the boundaries already passed; frame 0 is the reset-loaded idle frame
  localparam logic [3:0]  LOAD_CNT  = 4'(IDLE_FRAMES - 1);

  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             sel_q, sel_d;
  logic [3:0]       idle_cnt_q, idle_cnt_d;
  logic [1:0][31:0] shift_q, shift_d;
  logic [1:0][31:0] hold_q, hold_d;
  logic [1:0]       active_q, active_d;
  logic [1:0]       hold_v_q, hold_v_d;
  logic             frame_end, load_ok, accept;

  assign ready_out     = ~hold_v_q[sel_q];
  assign accept        = valid_in & ready_out;
  assign frame_end     = (bit_cnt_q == 5'd31);
  assign load_ok       = (idle_cnt_q >= LOAD_CNT);

  assign phy_tx_out_0  = shift_q[0][31];
  assign phy_tx_out_1  = shift_q[1][31];
  assign lane_active_0 = active_q[0];
  assign lane_active_1 = active_q[1];

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 5'd1;
    sel_d      = sel_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    active_d   = active_q;
    hold_v_d   = hold_v_q;

    if (frame_end && idle_cnt_q != 4'd15) begin
      idle_cnt_d = idle_cnt_q + 4'd1;
    end

    for (int l = 0; l < 2; l++) begin
      if (!frame_end) begin
        shift_d[l] = {shift_q[l][30:0], 1'b0};
      end else if (load_ok && hold_v_q[l]) begin
        shift_d[l]  = hold_q[l];
        active_d[l] = 1'b1;
        hold_v_d[l] = 1'b0;
      end else begin
        shift_d[l]  = IDLE_WORD;
        active_d[l] = 1'b0;
      end
    end

    // accept targets an empty slot, drain an occupied one, so they never collide
    if (accept) begin
      hold_d[sel_q]   = data_in;
      hold_v_d[sel_q] = 1'b1;
      sel_d           = ~sel_q;
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= 5'd0;
      sel_q      <= 1'b0;
      idle_cnt_q <= 4'd0;
      shift_q    <= {IDLE_WORD, IDLE_WORD};
      hold_q     <= '0;
      active_q   <= 2'b00;
      hold_v_q   <= 2'b00;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      sel_q      <= sel_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      active_q   <= active_d;
      hold_v_q   <= hold_v_d;
    end
  end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// tb/tb_phy_tx_serializer.sv - randomized scoreboard bench for phy_tx_serializer
module tb_phy_tx_serializer;

  localparam logic [7:0]  IDLE_BYTE   = 8'hBC;
  localparam int          IDLE_FRAMES = 1;
  localparam logic [31:0] IDLE_WORD   = {4{IDLE_BYTE}};

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        phy_tx_out_0, phy_tx_out_1;
  logic        lane_active_0, lane_active_1;

  phy_tx_serializer #(.IDLE_BYTE(IDLE_BYTE), .IDLE_FRAMES(IDLE_FRAMES)) dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .phy_tx_out_0 (phy_tx_out_0),
    .phy_tx_out_1 (phy_tx_out_1),
    .lane_active_0(lane_active_0),
    .lane_active_1(lane_active_1)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [31:0] word;
    int          frame;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always @(posedge clk_32f or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a word occupies its lane slot until the boundary that launches its frame.
  bit sel_m;
  bit busy_m [2];
  int busy_until [2];
  int last_frame [2];

  task automatic clear_model();
    q0.delete();
    q1.delete();
    sel_m = 1'b0;
    for (int l = 0; l < 2; l++) begin
      busy_m[l] = 1'b0;
      busy_until[l] = 0;
      last_frame[l] = -1;
    end
  endtask

  always @(negedge clk_32f) begin
    if (!reset) begin
      bit   exp_ready;
      exp_t e;
      for (int l = 0; l < 2; l++)
        if (busy_m[l] && cyc > busy_until[l]) busy_m[l] = 1'b0;
      exp_ready = !busy_m[sel_m];
      chk("ready_out", 64'(ready_out), 64'(exp_ready));
      if (valid_in && exp_ready) begin
        e.word  = data_in;
        e.frame = (cyc + 1) / 32 + 1;
        if (e.frame < IDLE_FRAMES) e.frame = IDLE_FRAMES;
        if (e.frame <= last_frame[sel_m]) e.frame = last_frame[sel_m] + 1;
        last_frame[sel_m] = e.frame;
        busy_m[sel_m]     = 1'b1;
        busy_until[sel_m] = e.frame * 32 - 1;
        if (sel_m) q1.push_back(e);
        else       q0.push_back(e);
        sel_m = ~sel_m;
      end
    end
  end

  // Monitor: rebuilds each lane's 32-bit frame from the wire and pops the scoreboard.
  logic [31:0] acc [2];
  bit          act_f [2];
  bit          stab [2];

  task automatic check_lane(input int l, input int frm);
    exp_t e;
    bit   have, ok;
    chk($sformatf("lane%0d active stable", l), 64'(stab[l]), 64'd1);
    if (act_f[l]) begin
      have = (l == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        chk($sformatf("lane%0d unexpected word", l), {32'(frm), acc[l]}, 64'hFFFFFFFF_FFFFFFFF);
      end else begin
        e = (l == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("lane%0d frame/word", l), {32'(frm), acc[l]}, {32'(e.frame), e.word});
      end
    end else begin
      chk($sformatf("lane%0d idle pattern", l), 64'(acc[l]), 64'(IDLE_WORD));
      if (l == 0) ok = (q0.size() == 0) || (q0[0].frame > frm);
      else        ok = (q1.size() == 0) || (q1[0].frame > frm);
      chk($sformatf("lane%0d no missed word", l), 64'(ok), 64'd1);
    end
  endtask

  always @(negedge clk_32f) begin
    if (!reset) begin
      int pos;
      pos = cyc % 32;
      if (pos == 0) begin
        act_f[0] = lane_active_0;
        act_f[1] = lane_active_1;
        stab[0]  = 1'b1;
        stab[1]  = 1'b1;
        acc[0]   = '0;
        acc[1]   = '0;
      end
      if (lane_active_0 != act_f[0]) stab[0] = 1'b0;
      if (lane_active_1 != act_f[1]) stab[1] = 1'b0;
      acc[0] = {acc[0][30:0], phy_tx_out_0};
      acc[1] = {acc[1][30:0], phy_tx_out_1};
      if (pos == 31) begin
        check_lane(0, cyc / 32);
        check_lane(1, cyc / 32);
      end
    end
  end

  // Caller positions itself at a negedge; reset asserts asynchronously just after.
  task automatic assert_reset();
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    clear_model();
    #1;
    chk("reset ready_out", 64'(ready_out), 64'd1);
    chk("reset tx bits", {62'd0, phy_tx_out_1, phy_tx_out_0}, 64'd3);
    chk("reset lane_active", {62'd0, lane_active_1, lane_active_0}, 64'd0);
    repeat (2) @(posedge clk_32f);
    #2;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    assert_reset();
  endtask

  task automatic send(input logic [31:0] w);
    int k;
    k = 0;
    valid_in = 1'b1;
    data_in  = w;
    @(negedge clk_32f);
    while (!ready_out && k < 200) begin
      @(negedge clk_32f);
      k++;
    end
    if (k >= 200) chk("send timeout", 64'd0, 64'd1);
    @(posedge clk_32f);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_32f);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 400) begin
      @(posedge clk_32f);
      k++;
    end
    chk("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
    idle_cycles(40);
  endtask

  initial begin
    clear_model();
    do_reset();
    idle_cycles(96);

    do_reset();
    repeat (3) @(posedge clk_32f);
    #1;
    send(32'hDEADBEEF);
    drain();

    do_reset();
    idle_cycles(4);
    send(32'h11223344);
    send(32'h55667788);
    drain();

    do_reset();
    for (int i = 1; i <= 6; i++) send(32'(i));
    drain();

    do_reset();
    do begin
      @(posedge clk_32f);
      #1;
    end while (cyc != 63);
    send(32'hA5A5_0F0F);
    drain();

    do_reset();
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 40));
      send($urandom);
    end
    drain();

    do_reset();
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i));
    do @(negedge clk_32f); while (cyc != 44);
    assert_reset();
    idle_cycles(96);
    chk("post-abort scoreboard empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
